// File: rtl/composite_pkg.sv
// Shared encodings for the composite test-pattern generator: DAC level codes,
// pattern mode encoding and the gray-ramp bar index to level mapping.
package composite_pkg;

    localparam logic [2:0] SYNC  = 3'b000;
    localparam logic [2:0] BLACK = 3'b001;
    localparam logic [2:0] GRAY0 = 3'b010;
    localparam logic [2:0] GRAY1 = 3'b100;
    localparam logic [2:0] GRAY2 = 3'b011;
    localparam logic [2:0] GRAY3 = 3'b101;
    localparam logic [2:0] GRAY4 = 3'b110;
    localparam logic [2:0] GRAY5 = 3'b111;

    typedef enum logic [1:0] {
        MODE_CHECK = 2'd0,
        MODE_VBARS = 2'd1,
        MODE_HBARS = 2'd2,
        MODE_SOLID = 2'd3
    } mode_e;

    // Bar 0 is black, bars 1..6 climb the gray scale, bar 7 repeats the brightest.
    function automatic logic [2:0] ramp_code(input logic [2:0] idx);
        logic [2:0] code;
        case (idx)
            3'd0:    code = BLACK;
            3'd1:    code = GRAY0;
            3'd2:    code = GRAY1;
            3'd3:    code = GRAY2;
            3'd4:    code = GRAY3;
            3'd5:    code = GRAY4;
            3'd6:    code = GRAY5;
            3'd7:    code = GRAY5;
            default: code = BLACK;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/pixel_ce_div.sv
// Pixel-rate clock enable: pulses ce once every PIX_DIV cycles while run is high,
// restarting its phase whenever run drops.
module pixel_ce_div #(
    parameter int PIX_DIV = 1
) (
    input  logic sys_clk,
    input  logic rst,
    input  logic run,
    output logic ce
);

    localparam int DIV_W = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
    localparam logic [DIV_W-1:0] LAST = DIV_W'(PIX_DIV - 1);

    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] div_d;
    logic             ce_s;

    // Next divider count and enable pulse.
    always_comb begin
        div_d = div_q;
        ce_s  = 1'b0;
        if (run) begin
            if (div_q == LAST) begin
                ce_s  = 1'b1;
                div_d = {DIV_W{1'b0}};
            end else begin
                div_d = div_q + {{(DIV_W-1){1'b0}}, 1'b1};
            end
        end else begin
            div_d = {DIV_W{1'b0}};
        end
    end

    // Divider count register.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            div_q <= {DIV_W{1'b0}};
        end else begin
            div_q <= div_d;
        end
    end

    assign ce = ce_s;

endmodule

// File: rtl/pattern_generator.sv
// Composite-video test-pattern generator: emits a registered 3-bit DAC level per
// cycle during active lines, black elsewhere; the pattern mode changes only at frame start.
module pattern_generator
    import composite_pkg::*;
#(
    parameter int         H_W        = 16,
    parameter int         V_W        = 9,
    parameter int         CELL_LOG2  = 4,
    parameter int         BAR_LOG2   = 5,
    parameter int         PIX_DIV    = 1,
    parameter logic [2:0] SOLID_CODE = 3'b111
) (
    input  logic           sys_clk,
    input  logic           rst,
    input  logic           row_enable,
    input  logic [V_W-1:0] vert_c,
    input  logic           frame_start,
    input  logic [1:0]     mode_in,
    output logic [2:0]     pixel_signal,
    output logic [1:0]     active_mode
);

    logic [H_W-1:0] hcount_q;
    logic [H_W-1:0] hcount_d;
    mode_e          mode_q;
    mode_e          mode_d;
    logic [2:0]     pix_q;
    logic [2:0]     pix_d;

    logic           pix_ce_s;
    logic           checker_s;
    logic [2:0]     vidx_s;
    logic [2:0]     hidx_s;
    logic [2:0]     pat_s;
    logic           unused_vert_s;

    pixel_ce_div #(
        .PIX_DIV(PIX_DIV)
    ) u_pixel_ce_div (
        .sys_clk(sys_clk),
        .rst    (rst),
        .run    (row_enable),
        .ce     (pix_ce_s)
    );

    assign checker_s     = hcount_q[CELL_LOG2] ^ vert_c[CELL_LOG2];
    assign vidx_s        = hcount_q[BAR_LOG2+2:BAR_LOG2];
    assign hidx_s        = vert_c[BAR_LOG2+2:BAR_LOG2];
    assign unused_vert_s = ^vert_c;

    // Horizontal pixel counter: saturates rather than wrapping, clears between lines.
    always_comb begin
        hcount_d = hcount_q;
        if (!row_enable) begin
            hcount_d = {H_W{1'b0}};
        end else if (pix_ce_s && (hcount_q != {H_W{1'b1}})) begin
            hcount_d = hcount_q + {{(H_W-1){1'b0}}, 1'b1};
        end else begin
            hcount_d = hcount_q;
        end
    end

    // Mode latch: sampled only on frame_start so a frame never mixes patterns.
    always_comb begin
        mode_d = mode_q;
        if (frame_start) begin
            mode_d = mode_e'(mode_in);
        end else begin
            mode_d = mode_q;
        end
    end

    // Pattern level for the current pixel, using the mode already in force.
    always_comb begin
        pat_s = BLACK;
        case (mode_q)
            MODE_CHECK: begin
                if (checker_s) begin
                    pat_s = BLACK;
                end else begin
                    pat_s = GRAY2;
                end
            end
            MODE_VBARS: pat_s = ramp_code(vidx_s);
            MODE_HBARS: pat_s = ramp_code(hidx_s);
            MODE_SOLID: pat_s = SOLID_CODE;
            default:    pat_s = BLACK;
        endcase
    end

    // Output select: blanking forces black immediately rather than holding.
    always_comb begin
        pix_d = BLACK;
        if (row_enable) begin
            pix_d = pat_s;
        end else begin
            pix_d = BLACK;
        end
    end

    // State and output registers.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            hcount_q <= {H_W{1'b0}};
            mode_q   <= MODE_CHECK;
            pix_q    <= BLACK;
        end else begin
            hcount_q <= hcount_d;
            mode_q   <= mode_d;
            pix_q    <= pix_d;
        end
    end

    assign pixel_signal = pix_q;
    assign active_mode  = mode_q;

endmodule

// File: tb/tb_pattern_generator.sv
// Directed bench for pattern_generator: three instances (defaults, PIX_DIV=3,
// narrow saturating counter) share stimulus; a reference model queues expectations.
module tb_pattern_generator;

    logic       clk;
    logic       rst;
    logic       row_enable;
    logic [8:0] vert_c;
    logic       frame_start;
    logic [1:0] mode_in;

    logic [2:0] pix0, pix1, pix2;
    logic [1:0] mode0, mode1, mode2;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [8:0] pix;
        logic [1:0] mode;
    } exp_t;

    exp_t sb[$];

    int p_div  [3] = '{1, 3, 1};
    int p_bar  [3] = '{5, 5, 1};
    int p_hmax [3] = '{65535, 65535, 63};
    int m_h    [3] = '{0, 0, 0};
    int m_div  [3] = '{0, 0, 0};
    int m_mode     = 0;

    pattern_generator u_def (
        .sys_clk(clk), .rst(rst), .row_enable(row_enable), .vert_c(vert_c),
        .frame_start(frame_start), .mode_in(mode_in),
        .pixel_signal(pix0), .active_mode(mode0)
    );

    pattern_generator #(.PIX_DIV(3)) u_div (
        .sys_clk(clk), .rst(rst), .row_enable(row_enable), .vert_c(vert_c),
        .frame_start(frame_start), .mode_in(mode_in),
        .pixel_signal(pix1), .active_mode(mode1)
    );

    pattern_generator #(.H_W(6), .BAR_LOG2(1)) u_sat (
        .sys_clk(clk), .rst(rst), .row_enable(row_enable), .vert_c(vert_c),
        .frame_start(frame_start), .mode_in(mode_in),
        .pixel_signal(pix2), .active_mode(mode2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [2:0] code_of(input int idx);
        case (idx)
            0:       return 3'b001;
            1:       return 3'b010;
            2:       return 3'b100;
            3:       return 3'b011;
            4:       return 3'b101;
            5:       return 3'b110;
            default: return 3'b111;
        endcase
    endfunction

    function automatic logic [2:0] exp_pat(input int i, input int h, input int v, input int md);
        case (md)
            0:       return ((((h >> 4) ^ (v >> 4)) & 1) != 0) ? 3'b001 : 3'b011;
            1:       return code_of((h >> p_bar[i]) & 7);
            2:       return code_of((v >> p_bar[i]) & 7);
            default: return 3'b111;
        endcase
    endfunction

    task automatic chk3(input string tag, input logic [2:0] got, input logic [2:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %b exp %b", tag, got, exp);
        end
    endtask

    task automatic chk2(input string tag, input logic [1:0] got, input logic [1:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %0d exp %0d", tag, got, exp);
        end
    endtask

    // One clock: queue the model's prediction for this edge, then compare after it.
    task automatic step(input string tag);
        exp_t e;
        e.pix  = 9'b0;
        e.mode = 2'b00;
        for (int i = 0; i < 3; i++) begin
            if (rst || !row_enable) e.pix[i*3 +: 3] = 3'b001;
            else                    e.pix[i*3 +: 3] = exp_pat(i, m_h[i], int'(vert_c), m_mode);
        end
        if (rst) begin
            m_mode = 0;
            for (int i = 0; i < 3; i++) begin
                m_h[i]   = 0;
                m_div[i] = 0;
            end
        end else begin
            if (frame_start) m_mode = int'(mode_in);
            for (int i = 0; i < 3; i++) begin
                if (row_enable) begin
                    if (m_div[i] == p_div[i] - 1) begin
                        m_div[i] = 0;
                        if (m_h[i] < p_hmax[i]) m_h[i]++;
                    end else begin
                        m_div[i]++;
                    end
                end else begin
                    m_h[i]   = 0;
                    m_div[i] = 0;
                end
            end
        end
        e.mode = 2'(m_mode);
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk3({tag, " pix0"}, pix0, e.pix[2:0]);
        chk3({tag, " pix1"}, pix1, e.pix[5:3]);
        chk3({tag, " pix2"}, pix2, e.pix[8:6]);
        chk2({tag, " mode0"}, mode0, e.mode);
        chk2({tag, " mode1"}, mode1, e.mode);
        chk2({tag, " mode2"}, mode2, e.mode);
    endtask

    task automatic steps(input string tag, input int n);
        for (int k = 0; k < n; k++) step(tag);
    endtask

    initial begin
        rst         = 1'b1;
        row_enable  = 1'b0;
        vert_c      = 9'd0;
        frame_start = 1'b0;
        mode_in     = 2'd0;
        #1;
        chk3("reset pix0", pix0, 3'b001);
        chk3("reset pix2", pix2, 3'b001);
        chk2("reset mode0", mode0, 2'd0);
        steps("reset", 2);
        rst = 1'b0;
        steps("idle", 4);

        // Checkerboard, both vertical phases
        frame_start = 1'b1; mode_in = 2'd0;
        step("fs_check");
        frame_start = 1'b0;
        row_enable = 1'b1;
        steps("check_v0", 64);
        row_enable = 1'b0;
        step("check_blank");
        vert_c = 9'd16;
        row_enable = 1'b1;
        steps("check_v16", 64);
        row_enable = 1'b0;
        step("check_blank2");

        // Vertical ramp including the idx wrap at pixel 257
        frame_start = 1'b1; mode_in = 2'd1; vert_c = 9'd0;
        step("fs_vbars");
        frame_start = 1'b0;
        row_enable = 1'b1;
        steps("vbars", 257);
        row_enable = 1'b0;
        step("vbars_blank");

        // Horizontal ramp across all eight bar indices
        frame_start = 1'b1; mode_in = 2'd2;
        step("fs_hbars");
        frame_start = 1'b0;
        for (int v = 0; v < 8; v++) begin
            vert_c = 9'(v * 32 + 5);
            row_enable = 1'b1;
            steps("hbars", 4);
            row_enable = 1'b0;
            step("hbars_blank");
        end

        // Checker with divider phase restart mid-pixel
        frame_start = 1'b1; mode_in = 2'd0; vert_c = 9'd0;
        step("fs_check2");
        frame_start = 1'b0;
        row_enable = 1'b1;
        steps("div_run", 100);
        row_enable = 1'b0;
        step("div_drop");
        row_enable = 1'b1;
        steps("div_restart", 20);

        // Mode change ignored without frame_start, applied one cycle after it
        mode_in = 2'd3;
        steps("mode_ignored", 10);
        frame_start = 1'b1;
        step("mode_latch_same");
        frame_start = 1'b0;
        steps("mode_latch_next", 5);
        row_enable = 1'b0;
        step("solid_blank");

        // Saturation of the narrow counter in vbars mode
        frame_start = 1'b1; mode_in = 2'd1;
        step("fs_sat");
        frame_start = 1'b0;
        row_enable = 1'b1;
        steps("saturate", 100);

        // Asynchronous reset mid-line
        rst = 1'b1;
        #1;
        chk3("async_rst pix0", pix0, 3'b001);
        chk3("async_rst pix1", pix1, 3'b001);
        chk3("async_rst pix2", pix2, 3'b001);
        chk2("async_rst mode0", mode0, 2'd0);
        step("rst_hold");
        rst = 1'b0;
        steps("post_rst", 20);
        row_enable = 1'b0;
        steps("final_idle", 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
